// File: rtl/regseq_pkg.sv
// Shared types and constants for the register-file sequencer.
//   state_t : sequencer FSM states
//   cmd_t   : command fields latched at accept
package regseq_pkg;

    localparam int unsigned DATA_W        = 6;
    localparam int unsigned ADDR_W        = 3;
    localparam int unsigned WDOG_W        = 4;
    localparam int unsigned EXEC_TMO_DFLT = 15;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        EXEC = 3'd3,
        WB   = 3'd4
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] rs1;
        logic [ADDR_W-1:0] rs2;
        logic [ADDR_W-1:0] rd;
        logic              use_rs2;
        logic              wb;
    } cmd_t;

endpackage

// File: rtl/exec_watchdog.sv
// EXEC-phase watchdog: counts cycles while enabled, flags when the count hits TMO.
//   clk, reset : clock, async active-low reset
//   clear      : zero the counter (priority over en)
//   en         : count this cycle
//   tmo        : registered, high while count == TMO
module exec_watchdog
    import regseq_pkg::*;
#(
    parameter int unsigned TMO = EXEC_TMO_DFLT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tmo
);

    logic [WDOG_W-1:0] count;
    logic [WDOG_W-1:0] count_d;

    // Saturating next count so a stuck enable never wraps back to a small value
    always_comb begin
        count_d = count;
        if (clear) begin
            count_d = '0;
        end else if (en && (count != {WDOG_W{1'b1}})) begin
            count_d = count + WDOG_W'(1);
        end
    end

    // tmo is decoded from the next count so it lines up with the counter itself
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            tmo   <= 1'b0;
        end else begin
            count <= count_d;
            tmo   <= (count_d == WDOG_W'(TMO));
        end
    end

endmodule

// File: rtl/regfile_sequencer.sv
// Sequences one instruction through the single-port register file:
// read rs1 (and optionally rs2), start the ALU, wait for the result, write rd.
//   clk, reset                 : clock, async active-low reset
//   cmd_valid/cmd_ready, cmd_* : command handshake from decode
//   rf_addr/rf_wdata/rf_we     : register-file master (write sampled on negedge)
//   rf_rdata                   : combinational read data
//   alu_a/alu_b/alu_start      : operand latches and start pulse
//   alu_done/alu_result        : ALU completion
//   done, err, busy            : retire pulse, timeout flag, not-idle
module regfile_sequencer
    import regseq_pkg::*;
#(
    parameter int unsigned EXEC_TMO = EXEC_TMO_DFLT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_rs1,
    input  logic [ADDR_W-1:0] cmd_rs2,
    input  logic              cmd_use_rs2,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic              cmd_wb,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rf_we,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_start,
    input  logic              alu_done,
    input  logic [DATA_W-1:0] alu_result,
    output logic              done,
    output logic              err,
    output logic              busy
);

    state_t            state;
    state_t            state_d;
    cmd_t              cmd_q;
    cmd_t              cmd_d;
    logic [ADDR_W-1:0] rf_addr_d;
    logic [DATA_W-1:0] rf_wdata_d;
    logic              rf_we_d;
    logic [DATA_W-1:0] alu_a_d;
    logic [DATA_W-1:0] alu_b_d;
    logic              alu_start_d;
    logic              done_d;
    logic              err_d;
    logic              accept;
    logic              write_back;
    logic              wdog_en;
    logic              wdog_clear;
    logic              tmo;

    assign cmd_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign accept     = cmd_valid && cmd_ready;
    // Writes to x0 are dropped entirely, including the WB cycle
    assign write_back = cmd_q.wb && (cmd_q.rd != REG_ZERO);

    // Counter runs while the next state is EXEC, so it reads k during the k-th EXEC cycle
    assign wdog_en    = (state_d == EXEC);
    assign wdog_clear = !wdog_en;

    exec_watchdog #(
        .TMO(EXEC_TMO)
    ) u_exec_watchdog (
        .clk  (clk),
        .reset(reset),
        .clear(wdog_clear),
        .en   (wdog_en),
        .tmo  (tmo)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic; alu_done wins over a same-cycle timeout
    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (accept) state_d = RD_A;
            RD_A: state_d = cmd_q.use_rs2 ? RD_B : EXEC;
            RD_B: state_d = EXEC;
            EXEC: begin
                if (alu_done) begin
                    state_d = write_back ? WB : IDLE;
                end else if (tmo) begin
                    state_d = IDLE;
                end
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and command latch
    always_comb begin
        cmd_d       = cmd_q;
        rf_addr_d   = rf_addr;
        rf_wdata_d  = rf_wdata;
        rf_we_d     = 1'b0;
        alu_a_d     = alu_a;
        alu_b_d     = alu_b;
        alu_start_d = 1'b0;
        done_d      = 1'b0;
        err_d       = err;
        case (state)
            IDLE: begin
                if (accept) begin
                    cmd_d     = '{rs1: cmd_rs1, rs2: cmd_rs2, rd: cmd_rd,
                                  use_rs2: cmd_use_rs2, wb: cmd_wb};
                    err_d     = 1'b0;
                    rf_addr_d = cmd_rs1;
                end
            end
            RD_A: begin
                alu_a_d = (cmd_q.rs1 == REG_ZERO) ? '0 : rf_rdata;
                if (cmd_q.use_rs2) begin
                    rf_addr_d = cmd_q.rs2;
                end else begin
                    alu_b_d     = '0;
                    alu_start_d = 1'b1;
                end
            end
            RD_B: begin
                alu_b_d     = (cmd_q.rs2 == REG_ZERO) ? '0 : rf_rdata;
                alu_start_d = 1'b1;
            end
            EXEC: begin
                if (alu_done) begin
                    if (write_back) begin
                        rf_addr_d  = cmd_q.rd;
                        rf_wdata_d = alu_result;
                        rf_we_d    = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end else if (tmo) begin
                    err_d  = 1'b1;
                    done_d = 1'b1;
                end
            end
            WB:      done_d = 1'b1;
            default: ;
        endcase
    end

    // Output and command registers; reset drops rf_we at once so no write escapes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd_q     <= '0;
            rf_addr   <= '0;
            rf_wdata  <= '0;
            rf_we     <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_start <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            cmd_q     <= cmd_d;
            rf_addr   <= rf_addr_d;
            rf_wdata  <= rf_wdata_d;
            rf_we     <= rf_we_d;
            alu_a     <= alu_a_d;
            alu_b     <= alu_b_d;
            alu_start <= alu_start_d;
            done      <= done_d;
            err       <= err_d;
        end
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Self-checking bench for regfile_sequencer: negedge-write register file model,
// adder ALU model with programmable latency, and a reference register array.
module tb_regfile_sequencer;
    import regseq_pkg::*;

    localparam int unsigned TMO = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_rs1;
    logic [ADDR_W-1:0] cmd_rs2;
    logic              cmd_use_rs2;
    logic [ADDR_W-1:0] cmd_rd;
    logic              cmd_wb;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_wdata;
    logic              rf_we;
    logic [DATA_W-1:0] rf_rdata;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic              alu_start;
    logic              alu_done = 1'b0;
    logic [DATA_W-1:0] alu_result = '0;
    logic              done;
    logic              err;
    logic              busy;

    always #5 clk = ~clk;

    regfile_sequencer #(.EXEC_TMO(TMO)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_use_rs2(cmd_use_rs2),
        .cmd_rd(cmd_rd), .cmd_wb(cmd_wb),
        .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_we(rf_we), .rf_rdata(rf_rdata),
        .alu_a(alu_a), .alu_b(alu_b), .alu_start(alu_start),
        .alu_done(alu_done), .alu_result(alu_result),
        .done(done), .err(err), .busy(busy)
    );

    int checks = 0;
    int passed = 0;

    // Register file environment model plus the bench's own expected contents
    logic [DATA_W-1:0] rf     [8] = '{default: '0};
    logic [DATA_W-1:0] ref_rf [8] = '{default: '0};
    logic              bd_we   = 1'b0;
    logic [2:0]        bd_addr = '0;
    logic [DATA_W-1:0] bd_data = '0;

    always @(negedge clk) begin
        if (bd_we) rf[bd_addr] = (bd_addr == 3'd0) ? '0 : bd_data;
        else if (rf_we && rf_addr != 3'd0) rf[rf_addr] = rf_wdata;
    end
    assign rf_rdata = (rf_addr == 3'd0) ? '0 : rf[rf_addr];

    // ALU model: result = a + b + salt, alu_done in the alu_n-th EXEC cycle
    int                alu_n    = 1;
    logic              alu_hold = 1'b0;
    logic [DATA_W-1:0] salt     = '0;
    logic              stray_en = 1'b0;
    logic              armed    = 1'b0;
    int                k        = 0;

    always @(negedge clk) begin
        if (!busy) armed = 1'b0;
        if (alu_start) begin
            armed = 1'b1;
            k     = 1;
        end else if (armed) begin
            k++;
        end
        if (armed && !alu_hold && k == alu_n) begin
            alu_done   = 1'b1;
            alu_result = 6'(alu_a + alu_b + salt);
            armed      = 1'b0;
        end else if (!armed && stray_en) begin
            alu_done   = 1'($urandom_range(0, 1));
            alu_result = 6'($urandom);
        end else begin
            alu_done   = 1'b0;
            alu_result = 6'($urandom);
        end
    end

    typedef struct {
        logic              ready_ok;
        logic              got_done;
        int                lat;
        int                nstart;
        logic [DATA_W-1:0] sa;
        logic [DATA_W-1:0] sb;
        int                we_cnt;
        logic [2:0]        we_addr;
        logic [DATA_W-1:0] we_data;
        logic              err_done;
        logic              err_c1;
        logic              bad_addr;
    } obs_t;

    obs_t o;
    obs_t o2;

    task automatic poke(input logic [2:0] a, input logic [DATA_W-1:0] d);
        @(posedge clk);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(posedge clk);
        bd_we = 1'b0;
        ref_rf[a] = (a == 3'd0) ? '0 : d;
    endtask

    // Drives one command (entered just after a negedge) and records what happened.
    // Latency counts negedges after the accept edge up to the one showing done.
    task automatic run_cmd(input logic [2:0] rs1, input logic [2:0] rs2, input logic use2,
                           input logic [2:0] rd, input logic wb, input int n,
                           input logic hold, input logic [DATA_W-1:0] s, output obs_t ob);
        ob.ready_ok = cmd_ready; ob.got_done = 1'b0; ob.lat = 0; ob.nstart = 0;
        ob.sa = '0; ob.sb = '0; ob.we_cnt = 0; ob.we_addr = '0; ob.we_data = '0;
        ob.err_done = 1'b0; ob.err_c1 = 1'b1; ob.bad_addr = 1'b0;
        alu_n = n; alu_hold = hold; salt = s;
        cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_use_rs2 = use2; cmd_rd = rd; cmd_wb = wb;
        cmd_valid = 1'b1;
        @(posedge clk);
        while (!ob.got_done && ob.lat < 60) begin
            @(negedge clk);
            ob.lat++;
            if (ob.lat == 1) begin
                ob.err_c1   = err;
                cmd_valid   = 1'($urandom_range(0, 1));
                cmd_rs1     = 3'($urandom);
                cmd_rs2     = 3'($urandom);
                cmd_rd      = 3'($urandom);
                cmd_use_rs2 = 1'($urandom);
                cmd_wb      = 1'($urandom);
            end
            if (alu_start) begin
                ob.nstart++; ob.sa = alu_a; ob.sb = alu_b;
            end
            if (rf_we) begin
                ob.we_cnt++; ob.we_addr = rf_addr; ob.we_data = rf_wdata;
            end
            if (!(rf_addr == rs1 || (use2 && rf_addr == rs2) || (wb && rf_addr == rd)))
                ob.bad_addr = 1'b1;
            if (done) begin
                ob.got_done = 1'b1; ob.err_done = err;
            end
        end
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [26:0] ov;
        reset = 1'b0; cmd_valid = 1'b0;
        cmd_rs1 = '0; cmd_rs2 = '0; cmd_use_rs2 = 1'b0; cmd_rd = '0; cmd_wb = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        ov = {rf_addr, rf_wdata, rf_we, alu_a, alu_b, alu_start, done, err, busy, cmd_ready};
        checks++;
        if (ov !== 27'd1) $display("FAIL reset_outputs got=%h exp=%h", ov, 27'd1);
        else passed++;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, cmd_ready, done} !== 3'b010) $display("FAIL idle_after_reset got=%b exp=010", {busy, cmd_ready, done});
        else passed++;
    endtask

    task automatic test_basic();
        poke(3'd3, 6'd5);
        poke(3'd4, 6'd9);
        @(negedge clk);
        run_cmd(3'd3, 3'd4, 1'b1, 3'd5, 1'b1, 1, 1'b0, 6'd0, o);
        checks++; if (o.got_done !== 1'b1) $display("FAIL basic_done_seen got=%b exp=1", o.got_done); else passed++;
        checks++; if (o.lat != 5) $display("FAIL basic_latency got=%0d exp=5", o.lat); else passed++;
        checks++; if (o.sa !== 6'd5) $display("FAIL basic_alu_a got=%0d exp=5", o.sa); else passed++;
        checks++; if (o.sb !== 6'd9) $display("FAIL basic_alu_b got=%0d exp=9", o.sb); else passed++;
        checks++; if (o.we_cnt != 1) $display("FAIL basic_we_cycles got=%0d exp=1", o.we_cnt); else passed++;
        checks++; if (o.we_addr !== 3'd5) $display("FAIL basic_we_addr got=%0d exp=5", o.we_addr); else passed++;
        checks++; if (rf[5] !== 6'd14) $display("FAIL basic_x5 got=%0d exp=14", rf[5]); else passed++;
        checks++; if (o.err_done !== 1'b0) $display("FAIL basic_err got=%b exp=0", o.err_done); else passed++;
        @(negedge clk);
        checks++; if (done !== 1'b0) $display("FAIL basic_done_pulse_width got=%b exp=0", done); else passed++;
        ref_rf[5] = 6'd14;
    endtask

    task automatic test_no_rs2();
        @(negedge clk);
        run_cmd(3'd3, 3'd4, 1'b0, 3'd6, 1'b1, 1, 1'b0, 6'd0, o);
        checks++; if (o.lat != 4) $display("FAIL no_rs2_latency got=%0d exp=4", o.lat); else passed++;
        checks++; if (o.sb !== 6'd0) $display("FAIL no_rs2_alu_b got=%0d exp=0", o.sb); else passed++;
        checks++; if (o.bad_addr !== 1'b0) $display("FAIL no_rs2_addr_touched got=%b exp=0", o.bad_addr); else passed++;
        checks++; if (rf[6] !== 6'd5) $display("FAIL no_rs2_x6 got=%0d exp=5", rf[6]); else passed++;
        ref_rf[6] = 6'd5;
    endtask

    task automatic test_rd_zero();
        @(negedge clk);
        run_cmd(3'd0, 3'd0, 1'b1, 3'd0, 1'b1, 1, 1'b0, 6'd7, o);
        checks++; if (o.we_cnt != 0) $display("FAIL rd0_we_cycles got=%0d exp=0", o.we_cnt); else passed++;
        checks++; if (o.lat != 4) $display("FAIL rd0_latency got=%0d exp=4", o.lat); else passed++;
        checks++; if (o.err_done !== 1'b0) $display("FAIL rd0_err got=%b exp=0", o.err_done); else passed++;
    endtask

    task automatic test_timeout();
        @(negedge clk);
        run_cmd(3'd3, 3'd4, 1'b1, 3'd5, 1'b1, 1, 1'b1, 6'd0, o);
        checks++; if (o.lat != 2 + 1 + TMO) $display("FAIL tmo_latency got=%0d exp=%0d", o.lat, 2 + 1 + TMO); else passed++;
        checks++; if (o.err_done !== 1'b1) $display("FAIL tmo_err got=%b exp=1", o.err_done); else passed++;
        checks++; if (o.we_cnt != 0) $display("FAIL tmo_we_cycles got=%0d exp=0", o.we_cnt); else passed++;
        @(negedge clk);
        checks++; if ({err, done} !== 2'b10) $display("FAIL tmo_err_hold got=%b exp=10", {err, done}); else passed++;
        run_cmd(3'd3, 3'd0, 1'b0, 3'd2, 1'b0, 2, 1'b0, 6'd0, o2);
        checks++; if (o2.err_c1 !== 1'b0) $display("FAIL tmo_err_clear got=%b exp=0", o2.err_c1); else passed++;
        checks++; if (o2.lat != 4) $display("FAIL nowb_latency got=%0d exp=4", o2.lat); else passed++;
        @(negedge clk);
        run_cmd(3'd3, 3'd4, 1'b1, 3'd0, 1'b0, int'(TMO), 1'b0, 6'd0, o);
        checks++; if (o.err_done !== 1'b0) $display("FAIL tmo_edge_err got=%b exp=0", o.err_done); else passed++;
        checks++; if (o.lat != 2 + 1 + TMO) $display("FAIL tmo_edge_latency got=%0d exp=%0d", o.lat, 2 + 1 + TMO); else passed++;
        @(negedge clk);
        run_cmd(3'd3, 3'd4, 1'b0, 3'd1, 1'b1, int'(TMO) + 1, 1'b0, 6'd0, o);
        checks++; if (o.err_done !== 1'b1) $display("FAIL tmo_late_err got=%b exp=1", o.err_done); else passed++;
        checks++; if (o.lat != 2 + TMO) $display("FAIL tmo_late_latency got=%0d exp=%0d", o.lat, 2 + TMO); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [DATA_W-1:0] snap [8];
        logic [26:0]       ov;
        logic              same;
        @(negedge clk);
        snap = rf;
        alu_hold = 1'b1;
        cmd_rs1 = 3'd3; cmd_rs2 = 3'd4; cmd_use_rs2 = 1'b1; cmd_rd = 3'd5; cmd_wb = 1'b1;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (busy !== 1'b1) $display("FAIL rstmid_busy_before got=%b exp=1", busy); else passed++;
        reset = 1'b0;
        #1;
        ov = {rf_addr, rf_wdata, rf_we, alu_a, alu_b, alu_start, done, err, busy, cmd_ready};
        checks++; if (ov !== 27'd1) $display("FAIL rstmid_outputs got=%h exp=%h", ov, 27'd1); else passed++;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        alu_hold = 1'b0;
        repeat (2) @(negedge clk);
        same = 1'b1;
        for (int j = 0; j < 8; j++) if (rf[j] !== snap[j]) same = 1'b0;
        checks++; if (same !== 1'b1) $display("FAIL rstmid_regs_changed got=%b exp=1", same); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL rstmid_idle_after got=%b exp=0", busy); else passed++;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        run_cmd(3'd0, 3'd0, 1'b0, 3'd2, 1'b1, 1, 1'b0, 6'd6, o);
        checks++; if (rf[2] !== 6'd6) $display("FAIL b2b_x2 got=%0d exp=6", rf[2]); else passed++;
        run_cmd(3'd2, 3'd0, 1'b0, 3'd7, 1'b1, 1, 1'b0, 6'd0, o2);
        checks++; if (o2.ready_ok !== 1'b1) $display("FAIL b2b_ready got=%b exp=1", o2.ready_ok); else passed++;
        checks++; if (o2.sa !== 6'd6) $display("FAIL b2b_alu_a got=%0d exp=6", o2.sa); else passed++;
        checks++; if (o2.lat != 4) $display("FAIL b2b_latency got=%0d exp=4", o2.lat); else passed++;
        checks++; if (rf[7] !== 6'd6) $display("FAIL b2b_x7 got=%0d exp=6", rf[7]); else passed++;
    endtask

    task automatic test_random();
        logic [2:0]        rs1, rs2, rd;
        logic              use2, wb, hold, tmo_e, do_wr;
        logic [DATA_W-1:0] s, ea, eb, res;
        int                n, elat;
        for (int j = 0; j < 8; j++) poke(3'(j), 6'($urandom));
        stray_en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            rs1  = 3'($urandom); rs2 = 3'($urandom); rd = 3'($urandom);
            use2 = 1'($urandom); wb = 1'($urandom);
            hold = ($urandom_range(0, 9) == 0);
            n    = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TMO - 1, TMO + 2))
                                                : int'($urandom_range(1, 6));
            s    = 6'($urandom);
            ea    = (rs1 == 3'd0) ? '0 : ref_rf[rs1];
            eb    = (!use2 || rs2 == 3'd0) ? '0 : ref_rf[rs2];
            res   = 6'(ea + eb + s);
            tmo_e = hold || (n > int'(TMO));
            do_wr = wb && (rd != 3'd0) && !tmo_e;
            elat  = 2 + int'(use2) + (tmo_e ? int'(TMO) : n) + (do_wr ? 1 : 0);
            run_cmd(rs1, rs2, use2, rd, wb, n, hold, s, o);
            checks++; if (o.ready_ok !== 1'b1) $display("FAIL rnd%0d_ready got=%b exp=1", i, o.ready_ok); else passed++;
            checks++; if (o.lat != elat) $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, o.lat, elat); else passed++;
            checks++; if (o.nstart != 1) $display("FAIL rnd%0d_start_pulses got=%0d exp=1", i, o.nstart); else passed++;
            checks++; if (o.sa !== ea) $display("FAIL rnd%0d_alu_a got=%0d exp=%0d", i, o.sa, ea); else passed++;
            checks++; if (o.sb !== eb) $display("FAIL rnd%0d_alu_b got=%0d exp=%0d", i, o.sb, eb); else passed++;
            checks++; if (o.err_done !== tmo_e) $display("FAIL rnd%0d_err got=%b exp=%b", i, o.err_done, tmo_e); else passed++;
            checks++; if (o.err_c1 !== 1'b0) $display("FAIL rnd%0d_err_clear got=%b exp=0", i, o.err_c1); else passed++;
            checks++; if (o.we_cnt != int'(do_wr)) $display("FAIL rnd%0d_we_cycles got=%0d exp=%0d", i, o.we_cnt, int'(do_wr)); else passed++;
            checks++; if (o.bad_addr !== 1'b0) $display("FAIL rnd%0d_addr got=%b exp=0", i, o.bad_addr); else passed++;
            if (do_wr) begin
                ref_rf[rd] = res;
                checks++;
                if ({o.we_addr, o.we_data} !== {rd, res})
                    $display("FAIL rnd%0d_wb got=x%0d<=%0d exp=x%0d<=%0d", i, o.we_addr, o.we_data, rd, res);
                else passed++;
            end
            for (int j = 0; j < 8; j++) begin
                checks++;
                if (rf[j] !== ref_rf[j]) $display("FAIL rnd%0d_x%0d got=%0d exp=%0d", i, j, rf[j], ref_rf[j]);
                else passed++;
            end
            if ($urandom_range(0, 1) == 0) @(negedge clk);
        end
        stray_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_no_rs2();
        test_rd_zero();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_time_limit got=running exp=finished");
        $fatal(1, "time limit");
    end

endmodule
